// File: rtl/time_setter.sv
// time_setter: debounced three-button HH:MM:SS editor that loads a new time into a clock.
// Optional hold-to-repeat on inc/dec is enabled by defining TIME_SETTER_AUTO_REPEAT_EN.
module time_setter #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned BLINK_DIV       = 8,
  parameter int unsigned REPEAT_DELAY    = 16,
  parameter int unsigned REPEAT_RATE     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic [5:0] cur_hours,
  input  logic [5:0] cur_minutes,
  input  logic [5:0] cur_seconds,
  output logic       set_mod,
  output logic [5:0] set_hours,
  output logic [5:0] set_minutes,
  output logic [5:0] set_seconds,
  output logic       editing,
  output logic [1:0] field_sel,
  output logic       field_blink
);

  localparam logic [7:0]  DbLast    = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] BlinkLast = 16'(BLINK_DIV - 1);
  localparam logic [5:0]  HourMax   = 6'd23;
  localparam logic [5:0]  MinSecMax = 6'd59;

  typedef enum logic [2:0] {
    StIdle,
    StEditH,
    StEditM,
    StEditS,
    StCommit
  } state_e;

  if (DEBOUNCE_CYCLES == 0 || DEBOUNCE_CYCLES > 255) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be in 1..255");
  end
  if (BLINK_DIV == 0) begin : g_bad_blink
    $error("BLINK_DIV must be at least 1");
  end
  if (REPEAT_DELAY == 0 || REPEAT_RATE == 0) begin : g_bad_repeat
    $error("REPEAT_DELAY and REPEAT_RATE must be at least 1");
  end

  // Button index: 0 = mode, 1 = inc, 2 = dec.
  logic [2:0] raw_btn;
  logic [2:0] sync1_q;
  logic [2:0] sync2_q;
  logic [2:0] level_q;
  logic [2:0] press_q;
  logic [7:0] db_cnt_q [3];

  assign raw_btn = {btn_dec, btn_inc, btn_mode};

  // A level flips only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      press_q <= '0;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q <= raw_btn;
      sync2_q <= sync1_q;
      press_q <= '0;
      for (int i = 0; i < 3; i++) begin
        if (sync2_q[i] != level_q[i]) begin
          if (db_cnt_q[i] == DbLast) begin
            level_q[i]  <= sync2_q[i];
            press_q[i]  <= sync2_q[i];
            db_cnt_q[i] <= '0;
          end else begin
            db_cnt_q[i] <= db_cnt_q[i] + 8'd1;
          end
        end else begin
          db_cnt_q[i] <= '0;
        end
      end
    end
  end

  logic mode_ev;
  logic inc_ev;
  logic dec_ev;

  assign mode_ev = press_q[0];

`ifdef TIME_SETTER_AUTO_REPEAT_EN
  localparam logic [15:0] RepDelay = 16'(REPEAT_DELAY);
  localparam logic [15:0] RepRate  = 16'(REPEAT_RATE);

  // Index 0 = inc, 1 = dec. cnt_q counts cycles since the last event of that button.
  logic [1:0]  rep_fast_q;
  logic [15:0] rep_cnt_q [2];
  logic [1:0]  rep_pulse;

  always_comb begin
    rep_pulse = '0;
    for (int j = 0; j < 2; j++) begin
      rep_pulse[j] = level_q[j+1] && !press_q[j+1] &&
                     (rep_cnt_q[j] == (rep_fast_q[j] ? RepRate : RepDelay));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rep_fast_q <= '0;
      for (int j = 0; j < 2; j++) rep_cnt_q[j] <= '0;
    end else begin
      for (int j = 0; j < 2; j++) begin
        if (!level_q[j+1]) begin
          rep_cnt_q[j]  <= '0;
          rep_fast_q[j] <= 1'b0;
        end else if (press_q[j+1]) begin
          rep_cnt_q[j]  <= 16'd1;
          rep_fast_q[j] <= 1'b0;
        end else if (rep_pulse[j]) begin
          rep_cnt_q[j]  <= 16'd1;
          rep_fast_q[j] <= 1'b1;
        end else begin
          rep_cnt_q[j]  <= rep_cnt_q[j] + 16'd1;
        end
      end
    end
  end

  assign inc_ev = press_q[1] | rep_pulse[0];
  assign dec_ev = press_q[2] | rep_pulse[1];
`else
  assign inc_ev = press_q[1];
  assign dec_ev = press_q[2];
`endif

  // Out-of-range values snap to 0 on any single step; inc+dec together is a no-op.
  function automatic logic [5:0] step_field(input logic [5:0] val, input logic [5:0] max_val,
                                            input logic up, input logic down);
    if (up == down) return val;
    if (val > max_val) return 6'd0;
    if (up) return (val == max_val) ? 6'd0 : val + 6'd1;
    return (val == 6'd0) ? max_val : val - 6'd1;
  endfunction

  logic [5:0] adj_hours;
  logic [5:0] adj_minutes;
  logic [5:0] adj_seconds;

  always_comb begin
    adj_hours   = step_field(set_hours, HourMax, inc_ev, dec_ev);
    adj_minutes = step_field(set_minutes, MinSecMax, inc_ev, dec_ev);
    adj_seconds = step_field(set_seconds, MinSecMax, inc_ev, dec_ev);
  end

  state_e      state_q;
  logic [15:0] blink_cnt_q;
  logic        blink_wrap;

  assign blink_wrap = (blink_cnt_q == BlinkLast);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      set_mod     <= 1'b0;
      editing     <= 1'b0;
      field_sel   <= 2'd0;
      field_blink <= 1'b0;
      blink_cnt_q <= '0;
      set_hours   <= '0;
      set_minutes <= '0;
      set_seconds <= '0;
    end else begin
      set_mod     <= 1'b0;
      field_blink <= field_blink ^ blink_wrap;
      blink_cnt_q <= blink_wrap ? '0 : blink_cnt_q + 16'd1;
      unique case (state_q)
        StIdle: begin
          field_blink <= 1'b0;
          blink_cnt_q <= '0;
          if (mode_ev) begin
            state_q     <= StEditH;
            set_hours   <= cur_hours;
            set_minutes <= cur_minutes;
            set_seconds <= cur_seconds;
            editing     <= 1'b1;
            field_sel   <= 2'd1;
            field_blink <= 1'b1;
          end
        end
        StEditH: begin
          if (mode_ev) begin
            state_q     <= StEditM;
            field_sel   <= 2'd2;
            field_blink <= 1'b1;
            blink_cnt_q <= '0;
          end else if (adj_hours != set_hours) begin
            set_hours   <= adj_hours;
            field_blink <= 1'b1;
            blink_cnt_q <= '0;
          end
        end
        StEditM: begin
          if (mode_ev) begin
            state_q     <= StEditS;
            field_sel   <= 2'd3;
            field_blink <= 1'b1;
            blink_cnt_q <= '0;
          end else if (adj_minutes != set_minutes) begin
            set_minutes <= adj_minutes;
            field_blink <= 1'b1;
            blink_cnt_q <= '0;
          end
        end
        StEditS: begin
          if (mode_ev) begin
            state_q     <= StCommit;
            set_mod     <= 1'b1;
            field_sel   <= 2'd0;
            field_blink <= 1'b0;
            blink_cnt_q <= '0;
          end else if (adj_seconds != set_seconds) begin
            set_seconds <= adj_seconds;
            field_blink <= 1'b1;
            blink_cnt_q <= '0;
          end
        end
        StCommit: begin
          state_q     <= StIdle;
          editing     <= 1'b0;
          field_blink <= 1'b0;
          blink_cnt_q <= '0;
        end
        default: begin
          state_q     <= StIdle;
          editing     <= 1'b0;
          field_sel   <= 2'd0;
          field_blink <= 1'b0;
          blink_cnt_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_time_setter.sv
// Bench for time_setter: directed button sequences; commits are checked by a set_mod scoreboard.
module tb_time_setter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic       btn_dec = 1'b0;
  logic [5:0] cur_hours = '0;
  logic [5:0] cur_minutes = '0;
  logic [5:0] cur_seconds = '0;
  logic       set_mod;
  logic [5:0] set_hours;
  logic [5:0] set_minutes;
  logic [5:0] set_seconds;
  logic       editing;
  logic [1:0] field_sel;
  logic       field_blink;

  always #5 clk = ~clk;

  time_setter #(
    .DEBOUNCE_CYCLES(4),
    .BLINK_DIV(8),
    .REPEAT_DELAY(16),
    .REPEAT_RATE(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_mode(btn_mode),
    .btn_inc(btn_inc),
    .btn_dec(btn_dec),
    .cur_hours(cur_hours),
    .cur_minutes(cur_minutes),
    .cur_seconds(cur_seconds),
    .set_mod(set_mod),
    .set_hours(set_hours),
    .set_minutes(set_minutes),
    .set_seconds(set_seconds),
    .editing(editing),
    .field_sel(field_sel),
    .field_blink(field_blink)
  );

  int          n_tests = 0;
  int          n_fail = 0;
  logic [17:0] exp_q [$];
  logic [17:0] mon_exp;
  logic        set_mod_prev = 1'b0;

  localparam logic [2:0] Mode = 3'b001;
  localparam logic [2:0] Inc  = 3'b010;
  localparam logic [2:0] Dec  = 3'b100;

`ifdef TIME_SETTER_AUTO_REPEAT_EN
  localparam int HeldSeconds = 58;
`else
  localparam int HeldSeconds = 51;
`endif

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [2:0] mask, input int hold);
    {btn_dec, btn_inc, btn_mode} = mask;
    cyc(hold);
    {btn_dec, btn_inc, btn_mode} = 3'b000;
    cyc(12);
  endtask

  task automatic set_cur(input int h, input int m, input int s);
    cur_hours   = 6'(h);
    cur_minutes = 6'(m);
    cur_seconds = 6'(s);
  endtask

  function automatic int hms(input int h, input int m, input int s);
    return (h << 12) | (m << 6) | s;
  endfunction

  // Commit monitor: every set_mod pulse must match the oldest expected time.
  always @(negedge clk) begin
    if (set_mod) begin
      n_tests++;
      if (set_mod_prev) begin
        n_fail++;
        $display("FAIL set_mod_width: got a pulse longer than 1 cycle, expected 1 cycle");
      end else if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL set_mod_unexpected: got commit %0d:%0d:%0d, expected no commit",
                 set_hours, set_minutes, set_seconds);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({set_hours, set_minutes, set_seconds} != mon_exp) begin
          n_fail++;
          $display("FAIL commit_value: got %0d:%0d:%0d, expected %0d:%0d:%0d",
                   set_hours, set_minutes, set_seconds,
                   mon_exp[17:12], mon_exp[11:6], mon_exp[5:0]);
        end
      end
    end
    set_mod_prev = set_mod;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    int toggles;
    logic prev_blink;

    // Reset with every button held.
    #2 reset = 1'b0;
    {btn_dec, btn_inc, btn_mode} = 3'b111;
    set_cur(12, 34, 56);
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      check("reset_outputs_zero",
            int'({set_mod, editing, field_blink, field_sel, set_hours, set_minutes, set_seconds}),
            0);
    end
    reset = 1'b1;
    k = 0;
    while (!editing && k < 20) begin
      cyc(1);
      k++;
    end
    check("held_at_release_editing", int'(editing), 1);
    check("held_at_release_sel", int'(field_sel), 1);
    check("held_at_release_load", int'({set_hours, set_minutes, set_seconds}), hms(12, 34, 56));
    cyc(20);
    check("held_single_mode_event", int'(field_sel), 1);
    check("held_no_field_change", int'(set_hours), 12);
    {btn_dec, btn_inc, btn_mode} = 3'b000;
    cyc(12);
    reset = 1'b0;
    cyc(2);
    check("abort_edit_h_editing", int'(editing), 0);
    reset = 1'b1;
    cyc(2);

    // Full pass with no changes.
    set_cur(12, 34, 56);
    press(Mode, 10);
    check("edit_h_sel", int'(field_sel), 1);
    check("edit_h_load", int'({set_hours, set_minutes, set_seconds}), hms(12, 34, 56));
    press(Mode, 10);
    check("edit_m_sel", int'(field_sel), 2);
    press(Mode, 10);
    check("edit_s_sel", int'(field_sel), 3);
    exp_q.push_back(18'(hms(12, 34, 56)));
    press(Mode, 10);
    check("idle_editing", int'(editing), 0);
    check("idle_sel", int'(field_sel), 0);
    check("idle_blink", int'(field_blink), 0);
    set_cur(1, 2, 3);
    cyc(3);
    check("idle_retain", int'({set_hours, set_minutes, set_seconds}), hms(12, 34, 56));
    press(Inc, 10);
    check("idle_inc_ignored", int'(set_hours), 12);

    // Wrap-around in each field.
    set_cur(23, 59, 0);
    press(Mode, 10);
    press(Inc, 10);
    check("wrap_hours_inc", int'(set_hours), 0);
    press(Mode, 10);
    press(Inc, 10);
    check("wrap_minutes_inc", int'(set_minutes), 0);
    press(Mode, 10);
    press(Dec, 10);
    check("wrap_seconds_dec", int'(set_seconds), 59);
    exp_q.push_back(18'(hms(0, 0, 59)));
    press(Mode, 10);

    // Bounce rejection in EDIT_M.
    set_cur(1, 30, 15);
    press(Mode, 10);
    press(Mode, 10);
    check("bounce_sel", int'(field_sel), 2);
    for (int g = 1; g <= 3; g++) begin
      btn_inc = 1'b1;
      cyc(g);
      btn_inc = 1'b0;
      cyc(8);
    end
    check("bounce_rejected", int'(set_minutes), 30);
    press(Inc, 10);
    check("clean_press_once", int'(set_minutes), 31);
    press(Dec, 10);
    check("dec_minutes", int'(set_minutes), 30);
    press(Mode, 10);
    exp_q.push_back(18'(hms(1, 30, 15)));
    press(Mode, 10);

    // Mode beats a simultaneous inc; reset in EDIT_S aborts without commit.
    set_cur(5, 10, 20);
    press(Mode, 10);
    press(Mode | Inc, 10);
    check("priority_sel", int'(field_sel), 2);
    check("priority_hours_kept", int'(set_hours), 5);
    press(Mode, 10);
    check("abort_sel_before", int'(field_sel), 3);
    reset = 1'b0;
    cyc(2);
    check("abort_editing", int'(editing), 0);
    check("abort_regs_cleared", int'({set_hours, set_minutes, set_seconds}), 0);
    reset = 1'b1;
    cyc(2);

    // Out-of-range load, inc+dec together, blink period.
    set_cur(30, 10, 50);
    press(Mode, 10);
    press(Dec, 10);
    check("out_of_range_to_zero", int'(set_hours), 0);
    press(Inc | Dec, 10);
    check("inc_dec_cancel", int'(set_hours), 0);
    prev_blink = field_blink;
    toggles = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(1);
      if (field_blink != prev_blink) toggles++;
      prev_blink = field_blink;
    end
    check("blink_toggles_16cyc", toggles, 2);
    press(Mode, 10);
    press(Mode, 10);
    check("hold_start_sel", int'(field_sel), 3);
    check("hold_start_seconds", int'(set_seconds), 50);

    // Long inc hold in EDIT_S.
    btn_inc = 1'b1;
    k = 0;
    while (set_seconds == 6'd50 && k < 20) begin
      cyc(1);
      k++;
    end
    check("hold_first_event", int'(set_seconds), 51);
    check("blink_forced_on_change", int'(field_blink), 1);
    cyc(35);
    btn_inc = 1'b0;
    cyc(15);
    check("hold_total", int'(set_seconds), HeldSeconds);
    exp_q.push_back(18'(hms(0, 10, HeldSeconds)));
    press(Mode, 10);
    check("final_idle", int'(editing), 0);

    cyc(5);
    check("commits_pending", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
